// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter feeding a single FIFO write port.
// Requester readies are combinational. The FIFO write data and enable are
// registered, so a word accepted at edge N is written in cycle N+1.
// Write-ack and overflow status from the FIFO are watched and latched into
// sticky error flags.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic                  fifo_almostfull,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_overflow,
  output logic                  last_grant,
  output logic [15:0]           wr_count,
  output logic                  ack_err,
  output logic                  ovf_err
);

  localparam int unsigned CNT_W = 16;
  // A zero-depth FIFO can never take a write.
  localparam logic DEPTH_OK = (FIFO_DEPTH != 0);

  logic                  rr_ptr_q,       rr_ptr_d;
  logic                  last_grant_q,   last_grant_d;
  logic [DATA_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
  logic                  fifo_wr_en_q,   fifo_wr_en_d;
  logic [CNT_W-1:0]      wr_count_q,     wr_count_d;
  logic                  ack_pend_q,     ack_pend_d;
  logic                  ack_err_q,      ack_err_d;
  logic                  ovf_err_q,      ovf_err_d;

  logic space_ok_c;
  logic grant0_c;
  logic grant1_c;
  logic accept_c;

  // Arbitration: FIFO room check and round-robin tie-break between requesters.
  always_comb begin
    space_ok_c = DEPTH_OK && !fifo_full && !(fifo_almostfull && fifo_wr_en_q);
    grant0_c   = rst_n && space_ok_c && req0_valid && (!req1_valid || !rr_ptr_q);
    grant1_c   = rst_n && space_ok_c && req1_valid && (!req0_valid ||  rr_ptr_q);
    accept_c   = grant0_c || grant1_c;
  end

  // Next-state: capture the accepted word and update pointer, count and error flags.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    last_grant_d   = last_grant_q;
    fifo_data_in_d = fifo_data_in_q;
    wr_count_d     = wr_count_q;
    fifo_wr_en_d   = accept_c;
    ack_pend_d     = fifo_wr_en_q;
    ack_err_d      = ack_err_q || (ack_pend_q && !fifo_wr_ack);
    ovf_err_d      = ovf_err_q || fifo_overflow;
    if (accept_c) begin
      fifo_data_in_d = grant1_c ? req1_data : req0_data;
      last_grant_d   = grant1_c;
      rr_ptr_d       = !grant1_c;
      wr_count_d     = wr_count_q + CNT_W'(1);
    end
  end

  // State registers; reset clears everything, dropping any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= 1'b0;
      last_grant_q   <= 1'b0;
      fifo_data_in_q <= '0;
      fifo_wr_en_q   <= 1'b0;
      wr_count_q     <= '0;
      ack_pend_q     <= 1'b0;
      ack_err_q      <= 1'b0;
      ovf_err_q      <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      last_grant_q   <= last_grant_d;
      fifo_data_in_q <= fifo_data_in_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      wr_count_q     <= wr_count_d;
      ack_pend_q     <= ack_pend_d;
      ack_err_q      <= ack_err_d;
      ovf_err_q      <= ovf_err_d;
    end
  end

  assign req0_ready   = grant0_c;
  assign req1_ready   = grant1_c;
  assign fifo_data_in = fifo_data_in_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign last_grant   = last_grant_q;
  assign wr_count     = wr_count_q;
  assign ack_err      = ack_err_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a FIFO status model plus a scoreboard of accepted words.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_wr_en;
  logic          fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic          last_grant;
  logic [15:0]   wr_count;
  logic          ack_err, ovf_err;

  // FIFO model state and fault-injection overrides
  int unsigned   f_cnt;
  logic          f_ack_q, f_ovf_q;
  logic          frc_nack = 1'b0, frc_ovf = 1'b0, frc_af = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [DW-1:0] data; logic grant; } exp_t;
  exp_t        sb[$];
  exp_t        sb_e;
  logic        mdl_rr = 1'b0, mdl_wr_en = 1'b0;
  logic [15:0] mdl_cnt = '0;
  logic        m_sp, m_e0, m_e1;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .last_grant(last_grant), .wr_count(wr_count),
    .ack_err(ack_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Downstream FIFO with no reads: registered count, ack and overflow
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt <= 0; f_ack_q <= 1'b0; f_ovf_q <= 1'b0;
    end else begin
      f_ack_q <= fifo_wr_en;
      f_ovf_q <= fifo_wr_en && (f_cnt == DEPTH);
      if (fifo_wr_en && f_cnt < DEPTH) f_cnt <= f_cnt + 1;
    end
  end
  assign fifo_full       = (f_cnt == DEPTH);
  assign fifo_almostfull = (f_cnt == DEPTH - 1) || frc_af;
  assign fifo_wr_ack     = f_ack_q && !frc_nack;
  assign fifo_overflow   = f_ovf_q || frc_ovf;

  // Reference model is cleared whenever reset asserts
  always @(negedge rst_n) begin
    sb.delete();
    mdl_rr = 1'b0; mdl_wr_en = 1'b0; mdl_cnt = '0;
  end

  // Scoreboard monitor: predicts readies, pushes accepts, pops on each write
  always @(negedge clk) begin
    if (rst_n) begin
      m_sp = !fifo_full && !(fifo_almostfull && mdl_wr_en);
      m_e0 = m_sp && req0_valid && (!req1_valid || !mdl_rr);
      m_e1 = m_sp && req1_valid && (!req0_valid ||  mdl_rr);
      checks++;
      if ({req0_ready, req1_ready} !== {m_e0, m_e1}) begin
        errors++;
        $display("FAIL readies t=%0t got=%b%b exp=%b%b", $time, req0_ready, req1_ready, m_e0, m_e1);
      end
      checks++;
      if (fifo_wr_en !== mdl_wr_en) begin
        errors++;
        $display("FAIL wr_en t=%0t got=%b exp=%b", $time, fifo_wr_en, mdl_wr_en);
      end
      checks++;
      if (wr_count !== mdl_cnt) begin
        errors++;
        $display("FAIL wr_count t=%0t got=%0d exp=%0d", $time, wr_count, mdl_cnt);
      end
      if (fifo_wr_en === 1'b1 && fifo_full) begin
        errors++;
        $display("FAIL write_when_full t=%0t got=1 exp=0", $time);
      end
      if (mdl_wr_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty t=%0t got=write exp=queued word", $time);
        end else begin
          sb_e = sb.pop_front();
          if (fifo_data_in !== sb_e.data || last_grant !== sb_e.grant) begin
            errors++;
            $display("FAIL sb_word t=%0t got=%h/g%b exp=%h/g%b", $time,
                     fifo_data_in, last_grant, sb_e.data, sb_e.grant);
          end
        end
      end
      if (m_e0 || m_e1) begin
        sb_e.data  = m_e1 ? req1_data : req0_data;
        sb_e.grant = m_e1;
        sb.push_back(sb_e);
        mdl_rr  = !m_e1;
        mdl_cnt = mdl_cnt + 16'd1;
      end
      mdl_wr_en = m_e0 || m_e1;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    frc_nack = 1'b0; frc_ovf = 1'b0; frc_af = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'h1234; req1_data = 16'h5678;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if ({fifo_wr_en, fifo_data_in, last_grant, wr_count, ack_err, ovf_err, req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%b/%h/%b/%h/%b/%b/%b%b exp=all zero", fifo_wr_en, fifo_data_in,
               last_grant, wr_count, ack_err, ovf_err, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'($urandom); req1_data = 16'($urandom);
    repeat (4) begin
      @(posedge clk); #1;
      req0_data = 16'($urandom); req1_data = 16'($urandom);
    end
    checks++;
    if (wr_count !== 16'd4 || last_grant !== 1'b1 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL alternate got cnt=%0d lg=%b we=%b exp cnt=4 lg=1 we=1", wr_count, last_grant, fifo_wr_en);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_req1();
    do_reset();
    req1_valid = 1'b1; req1_data = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL req1_only_ready got=%b%b exp=01", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hBEEF || last_grant !== 1'b1) begin
      errors++;
      $display("FAIL req1_only_write got=%b/%h/%b exp=1/beef/1", fifo_wr_en, fifo_data_in, last_grant);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fill();
    int   n   = 0;
    logic ovf = 1'b0;
    do_reset();
    req0_valid = 1'b1; req0_data = 16'($urandom);
    repeat (20) begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) n++;
      if (fifo_overflow !== 1'b0) ovf = 1'b1;
      @(posedge clk); #1 req0_data = 16'($urandom);
    end
    checks++;
    if (n != 8 || wr_count !== 16'd8) begin
      errors++;
      $display("FAIL fill_count got=%0d/%0d exp=8/8", n, wr_count);
    end
    checks++;
    if (req0_ready !== 1'b0 || ovf_err !== 1'b0 || ovf) begin
      errors++;
      $display("FAIL fill_full got rdy=%b ovf_err=%b ovf_seen=%b exp 0/0/0", req0_ready, ovf_err, ovf);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_almostfull();
    do_reset();
    frc_af = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL af_idle_accept got=%b%b exp=10", req0_ready, req1_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL af_block got we=%b rdy=%b%b exp we=1 rdy=00", fifo_wr_en, req0_ready, req1_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL af_resume got we=%b rdy=%b%b exp we=0 rdy=01", fifo_wr_en, req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0; frc_af = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_errors();
    do_reset();
    frc_nack = 1'b1; req0_valid = 1'b1; req0_data = 16'hA5A5;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_err_early got=%b exp=0", ack_err);
    end
    @(posedge clk); #1;
    checks++;
    if (ack_err !== 1'b1) begin
      errors++;
      $display("FAIL ack_err_set got=%b exp=1", ack_err);
    end
    frc_nack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack_err !== 1'b1 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_err_sticky got=%b/%b exp=1/0", ack_err, ovf_err);
    end
    frc_ovf = 1'b1;
    @(posedge clk); #1 frc_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err_set got=%b exp=1", ovf_err);
    end
    do_reset();
    #1;
    checks++;
    if (ack_err !== 1'b0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%b/%b exp=0/0", ack_err, ovf_err);
    end
  endtask

  task automatic test_async_reset();
    logic seen = 1'b0;
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h0F0F;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_wait got=no write exp=write within 10 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL async_drop got we=%b cnt=%0d exp we=0 cnt=0", fifo_wr_en, wr_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rr got=%b%b exp=10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (wr_count !== 16'd1 || last_grant !== 1'b0) begin
      errors++;
      $display("FAIL async_resume got cnt=%0d lg=%b exp cnt=1 lg=0", wr_count, last_grant);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_req1();
    test_fill();
    test_almostfull();
    test_errors();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of requester and FIFO write data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, depth of the downstream FIFO (informational; no internal storage sized by it).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester has a word.
REQ-007 SHALL have ports req0_data / req1_data  input  DATA_WIDTH  requester word.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  word accepted this cycle when valid&&ready.
REQ-009 SHALL have port fifo_data_in  output  DATA_WIDTH  registered FIFO write data.
REQ-010 SHALL have port fifo_wr_en  output  1  registered FIFO write enable.
REQ-011 SHALL have ports fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow  input  1 each  FIFO status.
REQ-012 SHALL have port last_grant  output  1  index of most recently accepted requester.
REQ-013 SHALL have port wr_count  output  16  total accepted words, wraps 0xFFFF->0x0000.
REQ-014 SHALL have ports ack_err, ovf_err  output  1 each  sticky error flags.

Function
REQ-015 SHALL compute space_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en), combinationally, each cycle.
REQ-016 SHALL assert at most one of req0_ready/req1_ready per cycle, both 0 when !space_ok.
REQ-017 SHALL, when space_ok and exactly one requester valid, assert that requester's ready.
REQ-018 SHALL, when space_ok and both valid, grant the requester selected by rr_ptr (1-bit round-robin pointer).
REQ-019 SHALL drive readies combinationally from current valids, space_ok and rr_ptr; ready SHALL not depend on data.
REQ-020 SHALL, on an accept of requester i at edge N, set rr_ptr=~i, last_grant=i, fifo_data_in=req_i_data, fifo_wr_en=1 for cycle N+1 (latency 1).
REQ-021 SHALL drive fifo_wr_en=0 in any cycle following a cycle with no accept; fifo_data_in SHALL hold its last value.
REQ-022 SHALL leave rr_ptr unchanged on cycles with no accept.
REQ-023 SHALL sustain one accept per cycle while space_ok holds (back-to-back alternation when both valid).
REQ-024 SHALL increment wr_count by 1 on every accept.
REQ-025 SHALL expect fifo_wr_ack=1 in the cycle after each fifo_wr_en=1 cycle; if 0, SHALL set ack_err=1 at that edge.
REQ-026 SHALL set ovf_err=1 at any edge where fifo_overflow=1; ack_err/ovf_err SHALL clear only on reset.
REQ-027 SHALL ignore FIFO read activity; space freed by reads is seen only via fifo_full/fifo_almostfull.
REQ-028 SHALL never issue fifo_wr_en=1 in a cycle where fifo_full=1, given a FIFO whose full/almostfull reflect its registered count.

Reset
REQ-029 SHALL, while rst_n=0, force fifo_wr_en=0, fifo_data_in=0, last_grant=0, wr_count=0, ack_err=0, ovf_err=0, rr_ptr=0 (requester 0 priority), and both readies 0.
REQ-030 SHALL, on reset assertion mid-transfer, drop a pending fifo_wr_en immediately (asynchronous); the word is lost and not counted.
REQ-031 SHALL resume arbitration on the first rising edge after rst_n deasserts, with no ack_err check for the pre-reset write.

Verification
REQ-032 Both valid continuously, FIFO empty, fifo_wr_ack looped from FIFO -> grants 0,1,0,1...; wr_count=4 after 4 cycles; fifo_data_in alternates req0/req1 data.
REQ-033 Only req1 valid with data 0xBEEF -> req1_ready=1, next cycle fifo_wr_en=1, fifo_data_in=0xBEEF, last_grant=1.
REQ-034 FIFO_DEPTH=8, no reads, req0 always valid -> exactly 8 writes, then readies 0; fifo_overflow never 1, ovf_err=0.
REQ-035 fifo_almostfull=1 while fifo_wr_en=1 -> both readies 0 that cycle; with fifo_wr_en=0 and almostfull=1 -> one accept.
REQ-036 Force fifo_wr_ack=0 after a write -> ack_err=1 next edge, stays 1 until rst_n=0; force fifo_overflow=1 -> ovf_err=1.
REQ-037 Assert rst_n=0 during fifo_wr_en=1 -> fifo_wr_en=0 without a clock edge; wr_count=0, rr_ptr=0 after release.
